// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder: sequencer states,
// default operand width and the drain-length helper.
package sa_pkg;

  localparam int unsigned DEF_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  // Cycles needed for the last beat to cross the far corner of an NxN array.
  function automatic int unsigned drain_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_skew_feeder_skew_line.sv
// DEPTH-stage W-bit shift chain with synchronous active-low reset and a
// synchronous clear; one instance per array lane provides the diagonal skew.
module skew_line
  import sa_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      for (int unsigned s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Upstream feeder for an NxN output-stationary systolic array: accepts K beats
// of A columns / B rows, skews lane i by i cycles, and sequences clear/feed/drain/done.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned K = 4,
  parameter int unsigned W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] a_edge,
  output logic [N*W-1:0] b_edge,
  output logic           pe_clear,
  output logic           busy,
  output logic           done
);

  localparam int unsigned DRAIN_CYCLES = drain_cycles(N);
  localparam int unsigned BW = $clog2(K + 1);
  localparam int unsigned DW = $clog2(2 * N);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(K - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t         r_state, w_state_nxt;
  logic [BW-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [DW-1:0]  r_drain_cnt, w_drain_cnt_nxt;
  logic           w_accept;
  logic           w_clear;
  logic [N*W-1:0] w_a_inj;
  logic [N*W-1:0] w_b_inj;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_accept        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_CLEAR;
          w_beat_cnt_nxt = '0;
        end
      end
      S_CLEAR: w_state_nxt = S_FEED;
      S_FEED: begin
        // A missing beat becomes a zero bubble; only real beats advance the count.
        if (in_valid) begin
          w_accept       = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (r_beat_cnt == BEAT_LAST) begin
            w_state_nxt     = S_DRAIN;
            w_drain_cnt_nxt = '0;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
        else                           w_drain_cnt_nxt = r_drain_cnt + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready = (r_state == S_FEED);
  assign pe_clear = (r_state == S_CLEAR);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_clear  = (r_state == S_CLEAR);

  assign w_a_inj = w_accept ? a_in : '0;
  assign w_b_inj = w_accept ? b_in : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DEPTH(i + 1),
      .W    (W)
    ) u_a_line (
      .clk    (clk),
      .rst    (rst),
      .i_clear(w_clear),
      .i_d    (w_a_inj[i*W +: W]),
      .o_q    (a_edge[i*W +: W])
    );

    skew_line #(
      .DEPTH(i + 1),
      .W    (W)
    ) u_b_line (
      .clk    (clk),
      .rst    (rst),
      .i_clear(w_clear),
      .i_d    (w_b_inj[i*W +: W]),
      .o_q    (b_edge[i*W +: W])
    );
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: table vectors, hand sequences and random traffic
// checked against a timeline model plus a 2x2 output-stationary array model.
module tb_sa_skew_feeder;

  localparam int N  = 2;
  localparam int K  = 4;
  localparam int W  = 8;
  localparam int LW = N * W;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [LW-1:0] a_in, b_in;
  logic          in_ready, pe_clear, busy, done;
  logic [LW-1:0] a_edge, b_edge;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sa_skew_feeder #(
    .N(N),
    .K(K),
    .W(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_edge  (a_edge),
    .b_edge  (b_edge),
    .pe_clear(pe_clear),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- timeline reference model ----------------
  bit            m_valid  = 0;
  bit            m_active = 0;
  int            m_ec = 0, m_ts = 0, m_acc = 0, m_tl = 0;
  logic [LW-1:0] m_ha [N];
  logic [LW-1:0] m_hb [N];
  int            exp_c [N][N];
  logic [LW-1:0] e_a, e_b;
  logic          e_clr, e_busy, e_rdy, e_done;

  // Called mid-cycle: inputs are stable; predicts outputs after the next edge.
  task automatic model_step();
    int n;
    bit pre_clear, pre_feed;
    n = m_ec;
    m_ec++;
    pre_clear = m_active && (n - 1 == m_ts);
    pre_feed  = m_active && (n - 1 > m_ts) && (m_acc < K);
    for (int d = N - 1; d > 0; d--) begin
      m_ha[d] = m_ha[d-1];
      m_hb[d] = m_hb[d-1];
    end
    m_ha[0] = '0;
    m_hb[0] = '0;
    if (!rst) begin
      m_active = 0;
      for (int d = 0; d < N; d++) begin m_ha[d] = '0; m_hb[d] = '0; end
      m_valid = 1;
    end else begin
      if (pre_clear) begin
        for (int d = 0; d < N; d++) begin m_ha[d] = '0; m_hb[d] = '0; end
      end else if (pre_feed && in_valid) begin
        m_ha[0] = a_in;
        m_hb[0] = b_in;
        m_acc++;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            exp_c[i][j] += int'(a_in[i*W +: W]) * int'(b_in[j*W +: W]);
        if (m_acc == K) m_tl = n;
      end
      if (m_active && m_acc == K && n == m_tl + 2 * N) begin
        m_active = 0;
      end else if (!m_active && start) begin
        m_active = 1;
        m_ts     = n;
        m_acc    = 0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) exp_c[i][j] = 0;
      end
    end
    e_busy = m_active;
    e_clr  = m_active && (n == m_ts);
    e_rdy  = m_active && (n > m_ts) && (m_acc < K);
    e_done = m_active && (m_acc == K) && (n == m_tl + 2 * N - 1);
    for (int i = 0; i < N; i++) begin
      e_a[i*W +: W] = m_ha[i][i*W +: W];
      e_b[i*W +: W] = m_hb[i][i*W +: W];
    end
  endtask

  // ---------------- downstream 2x2 array model ----------------
  int pa [N][N];
  int pb [N][N];
  int pacc [N][N];

  task automatic array_step();
    int na [N][N];
    int nb [N][N];
    int nacc [N][N];
    int ai, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = int'(a_edge[i*W +: W]);
        else        ai = pa[i][j-1];
        if (i == 0) bi = int'(b_edge[j*W +: W]);
        else        bi = pb[i-1][j];
        if (pe_clear === 1'b1) begin
          na[i][j] = 0; nb[i][j] = 0; nacc[i][j] = 0;
        end else begin
          na[i][j] = ai; nb[i][j] = bi; nacc[i][j] = pacc[i][j] + ai * bi;
        end
      end
    end
    pa   = na;
    pb   = nb;
    pacc = nacc;
  endtask

  // Continuous per-cycle comparison at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("a_edge",   a_edge,   e_a);
        chk("b_edge",   b_edge,   e_b);
        chk("pe_clear", pe_clear, e_clr);
        chk("busy",     busy,     e_busy);
        chk("in_ready", in_ready, e_rdy);
        chk("done",     done,     e_done);
        if (e_done)
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              chk($sformatf("array_c%0d%0d", i, j), pacc[i][j], exp_c[i][j]);
      end
      array_step();
      model_step();
    end
  end

  int edge_cnt = 0;
  int clr_cnt  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (pe_clear === 1'b1) clr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      tick();
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic run_tile(input logic [LW-1:0] av [K], input logic [LW-1:0] bv [K], output bit ok);
    start = 1; tick();
    start = 0; tick();
    for (int k = 0; k < K; k++) begin
      in_valid = 1; a_in = av[k]; b_in = bv[k];
      tick();
    end
    in_valid = 0;
    wait_done(40, ok);
  endtask

  typedef struct {
    logic          st, v;
    logic [LW-1:0] a, b, ea, eb;
    logic          clr, bsy, rdy, dn;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic v, input logic [LW-1:0] a,
                              input logic [LW-1:0] b, input logic [LW-1:0] ea,
                              input logic [LW-1:0] eb, input logic clr, input logic bsy,
                              input logic rdy, input logic dn);
    vec_t r;
    r.st = st; r.v = v; r.a = a; r.b = b; r.ea = ea; r.eb = eb;
    r.clr = clr; r.bsy = bsy; r.rdy = rdy; r.dn = dn;
    return r;
  endfunction

  vec_t          tbl [11];
  logic [LW-1:0] av [K];
  logic [LW-1:0] bv [K];
  int            ga [N][K];
  int            gb [K][N];
  int            c_ref;
  bit            ok, seen;
  int            e0, d1, d2, c1, c2;
  bit            pat [6];

  initial begin
    // Basic tile: a lanes (1,2),(3,4),(5,6),(7,8); b lanes (10,20)..(70,80).
    tbl[0]  = mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 0);
    tbl[2]  = mk(0, 1, 16'h0201, 16'h140A, 16'h0001, 16'h000A, 0, 1, 1, 0);
    tbl[3]  = mk(0, 1, 16'h0403, 16'h281E, 16'h0203, 16'h141E, 0, 1, 1, 0);
    tbl[4]  = mk(0, 1, 16'h0605, 16'h3C32, 16'h0405, 16'h2832, 0, 1, 1, 0);
    tbl[5]  = mk(0, 1, 16'h0807, 16'h5046, 16'h0607, 16'h3C46, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 16'hFFFF, 16'hFFFF, 16'h0800, 16'h5000, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);

    // Reset held with start and in_valid asserted.
    rst = 0; start = 1; in_valid = 1; a_in = '1; b_in = '1;
    repeat (3) tick();
    chk("rst_a_edge", a_edge, 0);
    chk("rst_b_edge", b_edge, 0);
    chk("rst_pe_clear", pe_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1; start = 0; in_valid = 0; a_in = '0; b_in = '0;
    repeat (2) tick();
    chk("idle_busy", busy, 0);

    for (int r = 0; r < 11; r++) begin
      start = tbl[r].st; in_valid = tbl[r].v; a_in = tbl[r].a; b_in = tbl[r].b;
      tick();
      chk($sformatf("tbl%0d_a_edge", r),   a_edge,   tbl[r].ea);
      chk($sformatf("tbl%0d_b_edge", r),   b_edge,   tbl[r].eb);
      chk($sformatf("tbl%0d_pe_clear", r), pe_clear, tbl[r].clr);
      chk($sformatf("tbl%0d_busy", r),     busy,     tbl[r].bsy);
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_done", r),     done,     tbl[r].dn);
    end
    start = 0; in_valid = 0;

    // Bubbles on FEED cycles 2 and 3 push done two cycles later.
    pat = '{1, 0, 0, 1, 1, 1};
    start = 1; tick(); e0 = edge_cnt;
    start = 0; tick();
    for (int c = 0; c < 6; c++) begin
      in_valid = pat[c]; a_in = LW'($urandom); b_in = LW'($urandom);
      tick();
    end
    in_valid = 0;
    wait_done(40, ok);
    chk("bubble_done_seen", ok, 1);
    chk("bubble_latency", edge_cnt - e0, 10);
    tick();

    // Golden products through the array model.
    ga = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}};
    gb = '{'{9, 10}, '{11, 12}, '{13, 14}, '{15, 16}};
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < K; k++) begin
        for (int i = 0; i < N; i++) begin
          av[k][i*W +: W] = (g == 0) ? W'(ga[i][k]) : '1;
          bv[k][i*W +: W] = (g == 0) ? W'(gb[k][i]) : '1;
        end
      end
      run_tile(av, bv, ok);
      chk($sformatf("golden%0d_done_seen", g), ok, 1);
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          c_ref = 0;
          for (int k = 0; k < K; k++)
            c_ref += (g == 0) ? ga[i][k] * gb[k][j] : 255 * 255;
          chk($sformatf("golden%0d_c%0d%0d", g, i, j), pacc[i][j], c_ref);
        end
      end
      tick();
    end

    // Reset in the middle of FEED abandons the tile.
    start = 1; tick();
    start = 0; tick();
    in_valid = 1;
    for (int k = 0; k < 2; k++) begin
      a_in = LW'($urandom); b_in = LW'($urandom);
      tick();
    end
    rst = 0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_a_edge", a_edge, 0);
    chk("midrst_b_edge", b_edge, 0);
    rst = 1; in_valid = 0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    chk("midrst_no_done", seen, 0);
    for (int k = 0; k < K; k++) begin av[k] = LW'($urandom); bv[k] = LW'($urandom); end
    run_tile(av, bv, ok);
    chk("midrst_retile_done", ok, 1);
    tick();

    // start held high: back-to-back tiles.
    start = 1; in_valid = 1; a_in = LW'($urandom); b_in = LW'($urandom);
    wait_done(60, ok);
    chk("held_done1_seen", ok, 1);
    d1 = edge_cnt; c1 = clr_cnt;
    tick();
    wait_done(60, ok);
    chk("held_done2_seen", ok, 1);
    d2 = edge_cnt; c2 = clr_cnt;
    chk("held_spacing", d2 - d1, 1 + K + (2 * N - 1) + 1 + 1);
    chk("held_clears", c2 - c1, 1);
    start = 0; in_valid = 0;
    tick();

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 500; c++) begin
      rst      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      start    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      a_in     = ($urandom_range(0, 7) == 0) ? '1 : LW'($urandom);
      b_in     = ($urandom_range(0, 7) == 0) ? '1 : LW'($urandom);
      tick();
    end
    rst = 1; start = 0; in_valid = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
